// File: rtl/cal_seq_sched_60m.sv
// ============================================================================
// Module   : cal_seq_sched_60m
// Brief    : Calibration-sequence scheduler; per enabled antenna drives a TX
//            window, a guard gap and an RX window after one frame header.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cal_seq_sched_60m #(
    parameter int SEQ_LEN = 128,
    parameter int GAP_LEN = 16,
    parameter int NUM_ANT = 8,
    localparam int ANT_W  = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1
) (
    input  logic               clk,
    input  logic               asy_rst,
    input  logic               i_seq_insert_en,
    input  logic               i_start,
    input  logic [NUM_ANT-1:0] i_ant_mask,
    input  logic               i_frame_hd,
    output logic               o_tx_seq_valid,
    output logic               o_rx_seq_valid,
    output logic [ANT_W-1:0]   o_ant_cnt,
    output logic [6:0]         o_seq_cnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_abort,
    output logic               o_err
);

    localparam logic [6:0] c_SEQ_LAST = 7'(SEQ_LEN - 1);
    localparam logic [7:0] c_GAP_LAST = 8'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_TX   = 3'd2,
        S_GAP  = 3'd3,
        S_RX   = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t             r_state;
    logic [NUM_ANT-1:0] r_pend;
    logic [7:0]         r_gap_cnt;
    logic               r_tx_valid;
    logic               r_rx_valid;
    logic [ANT_W-1:0]   r_ant_cnt;
    logic [6:0]         r_seq_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_abort;
    logic               r_err;

    logic [ANT_W-1:0]   w_low_idx;
    logic [NUM_ANT-1:0] w_low_oh;
    logic               w_pend_any;

    // r_pend holds the antennas still waiting for their windows
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_ANT - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_idx = ANT_W'(i);
            end
        end
    end

    assign w_low_oh   = r_pend & (~r_pend + NUM_ANT'(1));
    assign w_pend_any = |r_pend;

    always_ff @(posedge clk) begin
        if (asy_rst) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_gap_cnt  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_valid <= 1'b0;
            r_ant_cnt  <= '0;
            r_seq_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
            // DONE has already reported completion, so it is not abortable
            if (r_state != S_IDLE && r_state != S_DONE && !i_seq_insert_en) begin
                r_state    <= S_IDLE;
                r_pend     <= '0;
                r_gap_cnt  <= '0;
                r_tx_valid <= 1'b0;
                r_rx_valid <= 1'b0;
                r_ant_cnt  <= '0;
                r_seq_cnt  <= '0;
                r_busy     <= 1'b0;
                r_abort    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && i_seq_insert_en) begin
                            if (|i_ant_mask) begin
                                r_pend  <= i_ant_mask;
                                r_busy  <= 1'b1;
                                r_state <= S_ARM;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        if (i_frame_hd) begin
                            r_tx_valid <= 1'b1;
                            r_seq_cnt  <= '0;
                            r_ant_cnt  <= w_low_idx;
                            r_pend     <= r_pend & ~w_low_oh;
                            r_state    <= S_TX;
                        end
                    end
                    S_TX: begin
                        if (r_seq_cnt == c_SEQ_LAST) begin
                            r_tx_valid <= 1'b0;
                            r_seq_cnt  <= '0;
                            r_gap_cnt  <= '0;
                            r_state    <= S_GAP;
                        end else begin
                            r_seq_cnt <= r_seq_cnt + 7'd1;
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == c_GAP_LAST) begin
                            r_rx_valid <= 1'b1;
                            r_seq_cnt  <= '0;
                            r_state    <= S_RX;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 8'd1;
                        end
                    end
                    S_RX: begin
                        if (r_seq_cnt == c_SEQ_LAST) begin
                            r_rx_valid <= 1'b0;
                            r_seq_cnt  <= '0;
                            if (w_pend_any) begin
                                r_state <= S_NEXT;
                            end else begin
                                r_ant_cnt <= '0;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                                r_state   <= S_DONE;
                            end
                        end else begin
                            r_seq_cnt <= r_seq_cnt + 7'd1;
                        end
                    end
                    S_NEXT: begin
                        r_tx_valid <= 1'b1;
                        r_seq_cnt  <= '0;
                        r_ant_cnt  <= w_low_idx;
                        r_pend     <= r_pend & ~w_low_oh;
                        r_state    <= S_TX;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx_seq_valid = r_tx_valid;
    assign o_rx_seq_valid = r_rx_valid;
    assign o_ant_cnt      = r_ant_cnt;
    assign o_seq_cnt      = r_seq_cnt;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_abort        = r_abort;
    assign o_err          = r_err;

endmodule

`default_nettype wire
